// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared constants and entry type for the fetch unit.
// Optional stats ports are enabled with IFETCH_STATS_EN.
package ifetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ENTRY_W = 64;

    localparam logic [1:0] S_FETCH  = 2'd0;
    localparam logic [1:0] S_HALTED = 2'd1;
    localparam logic [1:0] S_FAULT  = 2'd2;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: DEPTH-entry queue of {pc, instr} fetch results.
// Flush has priority over push and pop; pointers wrap modulo DEPTH.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // next-state for storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // state registers, cleared on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: PC owner and fetch sequencer feeding decode via a queue.
// Define IFETCH_STATS_EN to add fetch_cnt/flush_cnt outputs.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fault
`ifdef IFETCH_STATS_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW       = AW + 1;
    localparam logic [32:0] PC_LIMIT = 33'(MEM_WORDS) << 2;

    logic [1:0]   state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         fault_q, fault_d;
    logic         push, flush, pop, push_ok, oor;
    logic         q_full, q_empty;
    logic [CW-1:0] q_count;
    fetch_entry_t q_din, q_dout;

    assign pop     = out_valid & out_ready;
    assign push_ok = ~q_full | pop;
    assign oor     = ({1'b0, pc_q} >= PC_LIMIT);
    assign q_din   = '{pc: pc_q, instr: imem_rd};

    // fetch FSM: redirect > halt > range fault > push/stall
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        push    = 1'b0;
        flush   = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    pc_d  = redirect_pc & ~32'h3;
                end else if (halt) begin
                    state_d = S_HALTED;
                end else if (oor) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                end else if (push_ok) begin
                    push = 1'b1;
                    pc_d = pc_q + 32'd4;
                end
            end
            S_HALTED: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    pc_d  = redirect_pc & ~32'h3;
                end else if (!halt) begin
                    state_d = S_FETCH;
                end
            end
            S_FAULT: begin
                if (redirect_valid) begin
                    flush   = 1'b1;
                    pc_d    = redirect_pc & ~32'h3;
                    fault_d = 1'b0;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // FSM, PC and sticky fault registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (q_din),
        .dout  (q_dout),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    assign imem_addr = pc_q;
    assign out_valid = ~q_empty;
    assign out_pc    = q_dout.pc;
    assign out_instr = q_dout.instr;
    assign fault     = fault_q;

`ifdef IFETCH_STATS_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // push and flushed-entry counters, free-running with wrap
    always_comb begin
        fetch_cnt_d = fetch_cnt_q + 32'(push);
        flush_cnt_d = flush_cnt_q;
        if (flush) begin
            flush_cnt_d = flush_cnt_q + 32'(q_count);
        end
    end

    // statistics registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    logic unused_count;
    assign unused_count = ^q_count;
`endif

endmodule
